alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station in front of the combinational ALU in the register-instruction path.
- Accepts decoded register/immediate ALU ops from dispatch, holds them until both operands are known (snooping the common data bus, CDB), and issues one ready op per cycle.
- The issue register drives the ALU's op1/op2/alu_op inputs directly; alu_dest travels alongside so the result can be broadcast on the CDB.

Parameters:
ENTRIES, 4, number of station slots (power of two, 2..16)
TAG_W, 4, width of reorder-buffer/rename tags

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous reset, active-low
rdy_in  input  1  global ready; low pauses the block
disp_valid  input  1  dispatch offers an op
disp_ready  output  1  a free slot exists
disp_alu_op  input  5  ALU opcode, passed through unchanged
disp_vj  input  32  operand 1 value (valid when disp_qj_valid=0)
disp_qj_valid  input  1  operand 1 still pending
disp_qj  input  TAG_W  producer tag of operand 1
disp_vk  input  32  operand 2 value or immediate
disp_qk_valid  input  1  operand 2 still pending
disp_qk  input  TAG_W  producer tag of operand 2
disp_dest  input  TAG_W  destination tag of this op
cdb_valid  input  1  CDB broadcast this cycle
cdb_tag  input  TAG_W  broadcast tag
cdb_value  input  32  broadcast value
alu_valid  output  1  issue register holds an op
alu_ready_in  input  1  downstream consumes the issued op this cycle
alu_op1  output  32  to ALU op1
alu_op2  output  32  to ALU op2
alu_op  output  5  to ALU alu_op
alu_dest  output  TAG_W  destination tag of the issued op

Behaviour:
- Reset (rst_in=0, async): all slots invalid. alu_valid=0. alu_op1, alu_op2, alu_op, alu_dest = 0. disp_ready forced 0 while rst_in=0, and 1 after release (station empty).
- rdy_in=0: every register holds. Dispatch, CDB and alu_ready_in are ignored. Outputs stay stable.
- Below, all actions happen at a rising edge with rst_in=1 and rdy_in=1.
- disp_ready: 1 when at least one slot is invalid. Computed from the current state only; a slot freed by issue in this cycle is not reusable until the next cycle.
- Dispatch accept (disp_valid & disp_ready): the op is written into the lowest-index free slot.
- Dispatch/CDB bypass: if cdb_valid and cdb_tag matches a pending disp_qj (or disp_qk) in the same cycle, store cdb_value and mark that operand ready. The same applies to both operands independently.
- Wake-up: every valid slot with a pending qj (or qk) equal to cdb_tag, while cdb_valid=1, captures cdb_value and clears its pending flag. Multiple slots may wake on one broadcast.
- Ready slot: valid and both pending flags clear.
- Issue select: the lowest-index ready slot, as seen at the start of the cycle.
- Issue register load condition: (alu_valid=0 or alu_ready_in=1) and a ready slot exists.
  - On load: alu_* take the selected slot's values, alu_valid=1, and the slot is invalidated.
  - If the condition is met but no slot is ready and alu_ready_in=1: alu_valid goes to 0.
  - If alu_valid=1 and alu_ready_in=0: the issue register holds; no slot leaves.
- Latency: op dispatched ready at edge N -> alu_valid=1 after edge N+1, assuming an empty issue register. An operand woken at edge N allows issue at edge N+1.
- Throughput: one issue per cycle.
- Full: ENTRIES slots occupied -> disp_ready=0. disp_valid is ignored, and dispatch holds its payload.
- Tag match uses all TAG_W bits. Tags are unique while in flight, and the block does not check for duplicates.
- alu_op is not decoded; unused encodings pass through unchanged.

Optional Feature:
- Macro ALU_RS_FLUSH_EN.
- With the macro: adds port flush_in (input, 1) for branch-mispredict recovery. flush_in=1 at an edge invalidates all slots and clears alu_valid. It overrides rdy_in, dispatch and CDB in that cycle. alu_* data are left unchanged.
- Without the macro: no flush_in port. Slots drain only by issue.

Test Plan:
1. Reset mid-operation: two slots valid, alu_valid=1, then drive rst_in=0 asynchronously between edges -> alu_valid=0 immediately and disp_ready=0. After release -> disp_ready=1 and the station is empty.
2. Ready dispatch: add, alu_op=5'b00001, vj=5, vk=7, dest=3, at edge N -> after edge N+1: alu_valid=1, alu_op1=5, alu_op2=7, alu_dest=3.
3. Wake-up: dispatch with qj=2 pending and vk=0x4 -> no issue. CDB tag=2, value=0x10 at edge M -> after M+1: alu_op1=0x10, alu_op2=0x4.
4. Bypass: dispatch qk=6 pending in the same cycle as cdb_valid, tag=6, value=0xFFFFFFFF -> issues at the next edge with alu_op2=0xFFFFFFFF.
5. Full and backpressure: fill 4 slots, all ready, with alu_ready_in=0.
   - disp_ready=0.
   - Issue register holds slot 0's op stable.
   - Raise alu_ready_in -> slots issue in index order 1, 2, 3 on consecutive cycles.
   - disp_ready=1 the cycle after the first free slot appears.
6. Pause: rdy_in=0 while a CDB tag matches a pending slot -> no capture and outputs stable. After rdy_in returns to 1, the same broadcast repeated -> capture occurs.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the combinational ALU.
// It buffers decoded ALU ops until both operands are known, by snooping the CDB.
// It then issues the lowest-index ready op into an output register that feeds the ALU.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global pause)
//   disp_*       : dispatch request; disp_ready is high while a slot is free
//   cdb_*        : common data bus broadcast (wake-up and dispatch bypass)
//   alu_*        : issue register; alu_valid/alu_ready_in handshake
//   flush_in     : present only with ALU_RS_FLUSH_EN; drops every op in flight
//
// Optional feature macro: ALU_RS_FLUSH_EN
module alu_rs #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
`ifdef ALU_RS_FLUSH_EN
  input  logic             flush_in,
`endif
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [4:0]       disp_alu_op,
  input  logic [31:0]      disp_vj,
  input  logic             disp_qj_valid,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_qk_valid,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [TAG_W-1:0] disp_dest,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             alu_valid,
  input  logic             alu_ready_in,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [4:0]       alu_op,
  output logic [TAG_W-1:0] alu_dest
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic             vld;
    logic [4:0]       op;
    logic [31:0]      vj;
    logic             qj_v;
    logic [TAG_W-1:0] qj;
    logic [31:0]      vk;
    logic             qk_v;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] dest;
  } slot_t;

  slot_t [ENTRIES-1:0] slot_q, slot_d;
  slot_t               new_ent;

  logic             alu_valid_q, alu_valid_d;
  logic [31:0]      alu_op1_q, alu_op1_d;
  logic [31:0]      alu_op2_q, alu_op2_d;
  logic [4:0]       alu_op_q, alu_op_d;
  logic [TAG_W-1:0] alu_dest_q, alu_dest_d;

  logic [ENTRIES-1:0] free_v, rdy_v;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic               any_free, any_rdy, accept, load, flush;

`ifdef ALU_RS_FLUSH_EN
  assign flush = flush_in;
`else
  assign flush = 1'b0;
`endif

  // Slot status is taken from registered state only, so a slot freed by
  // issue this cycle is neither free for dispatch nor reselected.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_stat
    assign free_v[i] = ~slot_q[i].vld;
    assign rdy_v[i]  = slot_q[i].vld & ~slot_q[i].qj_v & ~slot_q[i].qk_v;
  end

  // Lowest-index priority encoders (scan high to low, last hit wins)
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (free_v[i]) free_idx = IDX_W'(i);
      if (rdy_v[i])  sel_idx  = IDX_W'(i);
    end
  end

  assign any_free   = |free_v;
  assign any_rdy    = |rdy_v;
  assign disp_ready = rst_in & any_free;
  assign accept     = rdy_in & disp_valid & any_free;
  assign load       = rdy_in & (~alu_valid_q | alu_ready_in) & any_rdy;

  // Incoming op, with same-cycle CDB bypass on each pending operand
  always_comb begin
    new_ent      = '0;
    new_ent.vld  = 1'b1;
    new_ent.op   = disp_alu_op;
    new_ent.dest = disp_dest;
    new_ent.qj   = disp_qj;
    new_ent.qk   = disp_qk;
    new_ent.vj   = disp_vj;
    new_ent.vk   = disp_vk;
    new_ent.qj_v = disp_qj_valid;
    new_ent.qk_v = disp_qk_valid;
    if (cdb_valid && disp_qj_valid && (disp_qj == cdb_tag)) begin
      new_ent.vj   = cdb_value;
      new_ent.qj_v = 1'b0;
    end
    if (cdb_valid && disp_qk_valid && (disp_qk == cdb_tag)) begin
      new_ent.vk   = cdb_value;
      new_ent.qk_v = 1'b0;
    end
  end

  always_comb begin
    slot_d = slot_q;
    if (rdy_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (cdb_valid && slot_q[i].vld && slot_q[i].qj_v && (slot_q[i].qj == cdb_tag)) begin
          slot_d[i].vj   = cdb_value;
          slot_d[i].qj_v = 1'b0;
        end
        if (cdb_valid && slot_q[i].vld && slot_q[i].qk_v && (slot_q[i].qk == cdb_tag)) begin
          slot_d[i].vk   = cdb_value;
          slot_d[i].qk_v = 1'b0;
        end
        if (load && (sel_idx == IDX_W'(i)))  slot_d[i].vld = 1'b0;
        if (accept && (free_idx == IDX_W'(i))) slot_d[i] = new_ent;
      end
    end
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) slot_d[i].vld = 1'b0;
    end
  end

  // Issue register: data holds when nothing loads, only valid drops
  always_comb begin
    alu_valid_d = alu_valid_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    alu_op_d    = alu_op_q;
    alu_dest_d  = alu_dest_q;
    if (load) begin
      alu_valid_d = 1'b1;
      alu_op1_d   = slot_q[sel_idx].vj;
      alu_op2_d   = slot_q[sel_idx].vk;
      alu_op_d    = slot_q[sel_idx].op;
      alu_dest_d  = slot_q[sel_idx].dest;
    end else if (rdy_in && alu_ready_in) begin
      alu_valid_d = 1'b0;
    end
    if (flush) alu_valid_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      slot_q      <= '0;
      alu_valid_q <= 1'b0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_op_q    <= '0;
      alu_dest_q  <= '0;
    end else begin
      slot_q      <= slot_d;
      alu_valid_q <= alu_valid_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_op_q    <= alu_op_d;
      alu_dest_q  <= alu_dest_d;
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign alu_op    = alu_op_q;
  assign alu_dest  = alu_dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed ops push expected issue records,
// a negedge monitor pops and compares on each consumed issue.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        disp_valid, disp_ready;
  logic [4:0]  disp_alu_op;
  logic [31:0] disp_vj, disp_vk;
  logic        disp_qj_valid, disp_qk_valid;
  logic [3:0]  disp_qj, disp_qk, disp_dest;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        alu_valid, alu_ready_in;
  logic [31:0] alu_op1, alu_op2;
  logic [4:0]  alu_op;
  logic [3:0]  alu_dest;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  op;
    logic [3:0]  dest;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  alu_rs #(.ENTRIES(4), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
`ifdef ALU_RS_FLUSH_EN
    .flush_in(1'b0),
`endif
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_alu_op(disp_alu_op),
    .disp_vj(disp_vj), .disp_qj_valid(disp_qj_valid), .disp_qj(disp_qj),
    .disp_vk(disp_vk), .disp_qk_valid(disp_qk_valid), .disp_qk(disp_qk),
    .disp_dest(disp_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .alu_valid(alu_valid), .alu_ready_in(alu_ready_in),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op), .alu_dest(alu_dest)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] vj, input logic qjv,
                      input logic [3:0] qj, input logic [31:0] vk, input logic qkv,
                      input logic [3:0] qk, input logic [3:0] dest);
    disp_valid = 1'b1; disp_alu_op = op;
    disp_vj = vj; disp_qj_valid = qjv; disp_qj = qj;
    disp_vk = vk; disp_qk_valid = qkv; disp_qk = qk;
    disp_dest = dest;
  endtask

  task automatic push(input logic [31:0] o1, input logic [31:0] o2,
                      input logic [4:0] op, input logic [3:0] dest);
    exp_t e;
    e.op1 = o1; e.op2 = o2; e.op = op; e.dest = dest;
    exp_q.push_back(e);
  endtask

  // Monitor: an issue is consumed at the next edge when valid & ready & rdy_in
  initial begin
    exp_t got, want;
    forever begin
      @(negedge clk_in);
      if (rst_in && rdy_in && alu_valid && alu_ready_in) begin
        got.op1 = alu_op1; got.op2 = alu_op2; got.op = alu_op; got.dest = alu_dest;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL issue_unexpected: got %h want none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL issue_data: got %h want %h", got, want);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; alu_ready_in = 1'b1;
    disp_valid = 1'b0; disp_alu_op = '0; disp_vj = '0; disp_vk = '0;
    disp_qj_valid = 1'b0; disp_qk_valid = 1'b0; disp_qj = '0; disp_qk = '0; disp_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;

    // reset state
    #2;
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd0);
    chk("rst_op1", alu_op1, 32'd0);
    chk("rst_dest", 32'(alu_dest), 32'd0);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b1;
    #1;
    chk("rel_disp_ready", 32'(disp_ready), 32'd1);

    // ready dispatch: issue one edge after accept
    disp(5'd1, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
    push(32'd5, 32'd7, 5'd1, 4'd3);
    tick(); disp_valid = 1'b0;
    chk("lat_n", 32'(alu_valid), 32'd0);
    tick();
    chk("lat_n1_valid", 32'(alu_valid), 32'd1);
    chk("lat_op1", alu_op1, 32'd5);
    chk("lat_op2", alu_op2, 32'd7);
    chk("lat_dest", 32'(alu_dest), 32'd3);

    // wake-up via CDB
    disp(5'd2, 32'hBAD0, 1'b1, 4'd2, 32'h4, 1'b0, 4'd0, 4'd4);
    push(32'h10, 32'h4, 5'd2, 4'd4);
    tick(); disp_valid = 1'b0;
    tick();
    chk("wake_pending", 32'(alu_valid), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h10;
    tick(); cdb_valid = 1'b0;
    chk("wake_m", 32'(alu_valid), 32'd0);
    tick();
    chk("wake_valid", 32'(alu_valid), 32'd1);
    chk("wake_op1", alu_op1, 32'h10);

    // dispatch/CDB bypass
    disp(5'd9, 32'd9, 1'b0, 4'd0, 32'hDEAD, 1'b1, 4'd6, 4'd5);
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'hFFFFFFFF;
    push(32'd9, 32'hFFFFFFFF, 5'd9, 4'd5);
    tick(); disp_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    chk("byp_valid", 32'(alu_valid), 32'd1);
    chk("byp_op2", alu_op2, 32'hFFFFFFFF);
    tick();
    alu_ready_in = 1'b0;

    // full + backpressure: A goes to the issue register, C refills slot 0
    for (int k = 0; k < 5; k++) begin
      disp(5'(3 + k), 32'(32'h11 + k), 1'b0, 4'd0, 32'(32'h21 + k), 1'b0, 4'd0, 4'(8 + k));
      tick();
    end
    push(32'h11, 32'h21, 5'd3, 4'd8);
    push(32'h13, 32'h23, 5'd5, 4'd10);
    push(32'h12, 32'h22, 5'd4, 4'd9);
    push(32'h14, 32'h24, 5'd6, 4'd11);
    push(32'h15, 32'h25, 5'd7, 4'd12);
    chk("full_ready", 32'(disp_ready), 32'd0);
    chk("full_hold_op1", alu_op1, 32'h11);
    disp(5'd20, 32'h99, 1'b0, 4'd0, 32'h98, 1'b0, 4'd0, 4'd15);
    tick(); tick();
    chk("full_ignore", 32'(disp_ready), 32'd0);
    chk("bp_hold_op1", alu_op1, 32'h11);
    chk("bp_hold_valid", 32'(alu_valid), 32'd1);
    disp_valid = 1'b0;
    alu_ready_in = 1'b1;
    tick();
    chk("free_ready", 32'(disp_ready), 32'd1);
    chk("drain0", alu_op1, 32'h13);
    tick(); chk("drain1", alu_op1, 32'h12);
    tick(); chk("drain2", alu_op1, 32'h14);
    tick(); chk("drain3", alu_op1, 32'h15);
    tick(); chk("drain_empty", 32'(alu_valid), 32'd0);

    // pause: CDB ignored while rdy_in=0
    disp(5'd8, 32'd0, 1'b1, 4'd7, 32'd3, 1'b0, 4'd0, 4'd13);
    push(32'h55, 32'd3, 5'd8, 4'd13);
    tick(); disp_valid = 1'b0;
    rdy_in = 1'b0; cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'h55;
    tick(); tick();
    chk("pause_valid", 32'(alu_valid), 32'd0);
    rdy_in = 1'b1; cdb_valid = 1'b0;
    tick(); tick();
    chk("pause_nocap", 32'(alu_valid), 32'd0);
    cdb_valid = 1'b1;
    tick(); cdb_valid = 1'b0;
    tick();
    chk("pause_cap_valid", 32'(alu_valid), 32'd1);
    chk("pause_cap_op1", alu_op1, 32'h55);
    rdy_in = 1'b0;
    tick(); tick();
    chk("pause_hold_issue", 32'(alu_valid), 32'd1);
    rdy_in = 1'b1;
    tick();
    chk("pause_consumed", 32'(alu_valid), 32'd0);

    // asynchronous reset mid-operation
    alu_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp(5'(1 + k), 32'(k), 1'b0, 4'd0, 32'(k + 10), 1'b0, 4'd0, 4'(1 + k));
      tick();
    end
    disp_valid = 1'b0;
    chk("pre_rst_valid", 32'(alu_valid), 32'd1);
    #2;
    rst_in = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid", 32'(alu_valid), 32'd0);
    chk("arst_ready", 32'(disp_ready), 32'd0);
    chk("arst_op1", alu_op1, 32'd0);
    tick();
    rst_in = 1'b1;
    #1;
    chk("arel_ready", 32'(disp_ready), 32'd1);
    alu_ready_in = 1'b1;
    tick(); tick(); tick();
    chk("arel_empty", 32'(alu_valid), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
